// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: core writeback has priority, multiply/divide
// results wait in an in-order buffer with write-after-write kill and a starvation guard.
module rf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_we,
  input  logic        core_jal,
  input  logic [4:0]  core_dst,
  input  logic [31:0] core_res,
  input  logic [31:0] core_link,
  output logic        core_stall,
  input  logic        mu_valid,
  output logic        mu_ready,
  input  logic [4:0]  mu_dst,
  input  logic [31:0] mu_res,
  output logic [31:0] pend_mask,
  output logic        rf_we,
  output logic [4:0]  rf_wn,
  output logic [31:0] rf_wd,
  output logic        dbg_state_o,
  output logic [3:0]  dbg_age_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {NORM = 1'b0, FORCE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [3:0]        age_q, age_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [4:0]        dst_q  [DEPTH];
  logic [4:0]        dst_d  [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];
  logic [31:0]       pend_q, pend_d;

  logic        empty, full, ce, enq, deq;
  logic [4:0]  cdst;
  logic [31:0] cdata;

  // Handshake: a unit result transfers on a cycle where mu_valid and mu_ready are
  // both high; mu_ready depends only on the registered count, never on mu_valid.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(DEPTH));
    mu_ready   = ~full & ~rst;
    core_stall = (state_q == FORCE) & ~rst;
    ce         = core_we & ~core_stall & ~rst;
    cdst       = core_jal ? 5'd31 : core_dst;
    cdata      = core_jal ? core_link : core_res;
    enq        = mu_valid & mu_ready;
    // FORCE implies ce=0, so one condition covers both drain cases.
    deq        = ~empty & ~ce & ~rst;
  end

  always_comb begin
    rf_we = 1'b0;
    rf_wn = 5'd0;
    rf_wd = 32'd0;
    if (ce) begin
      rf_we = (cdst != 5'd0);
      rf_wn = cdst;
      rf_wd = cdata;
    end else if (deq) begin
      rf_we = valid_q[rd_ptr_q];
      rf_wn = dst_q[rd_ptr_q];
      rf_wd = data_q[rd_ptr_q];
    end
  end

  always_comb begin
    valid_d  = valid_q;
    dst_d    = dst_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pend_d   = 32'd0;

    // A younger core write to the same register makes buffered results obsolete.
    if (ce) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (dst_q[i] == cdst) valid_d[i] = 1'b0;
      end
    end
    if (deq) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (enq) begin
      valid_d[wr_ptr_q] = (mu_dst != 5'd0) & ~(ce & (mu_dst == cdst));
      dst_d[wr_ptr_q]   = mu_dst;
      data_d[wr_ptr_q]  = mu_res;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Freed slots have their valid bit cleared, so only live entries contribute.
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_d[i]) pend_d[dst_d[i]] = 1'b1;
    end
  end

  always_comb begin
    state_d = NORM;
    age_d   = 4'd0;
    if (state_q == NORM && !empty && ce) begin
      if (age_q + 4'd1 == 4'(STARVE_MAX)) state_d = FORCE;
      else                                 age_d   = age_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= NORM;
      age_q    <= 4'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      pend_q   <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i]  <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      state_q  <= state_d;
      age_q    <= age_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      pend_q   <= pend_d;
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i]  <= dst_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign pend_mask   = pend_q;
  assign dbg_state_o = state_q;
  assign dbg_age_o   = age_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: hand-computed vector tables, directed corner sequences,
// then random traffic checked against a queue-based reference model.
module tb_rf_wb_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst;
  logic        core_we, core_jal;
  logic [4:0]  core_dst;
  logic [31:0] core_res, core_link;
  logic        core_stall;
  logic        mu_valid, mu_ready;
  logic [4:0]  mu_dst;
  logic [31:0] mu_res;
  logic [31:0] pend_mask;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_wd;
  logic        dbg_state;
  logic [3:0]  dbg_age;

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .core_we(core_we), .core_jal(core_jal), .core_dst(core_dst),
    .core_res(core_res), .core_link(core_link), .core_stall(core_stall),
    .mu_valid(mu_valid), .mu_ready(mu_ready), .mu_dst(mu_dst), .mu_res(mu_res),
    .pend_mask(pend_mask), .rf_we(rf_we), .rf_wn(rf_wn), .rf_wd(rf_wd),
    .dbg_state_o(dbg_state), .dbg_age_o(dbg_age)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0] rf_shadow [32];
  always @(posedge clk) if (rf_we) rf_shadow[rf_wn] <= rf_wd;

  typedef struct {
    logic        we, jal;
    logic [4:0]  dst;
    logic [31:0] res, link;
    logic        mv;
    logic [4:0]  mdst;
    logic [31:0] mres;
    logic        e_we, e_wchk;
    logic [4:0]  e_wn;
    logic [31:0] e_wd;
    logic        e_stall, e_ready;
    logic [31:0] e_pend;
  } vec_t;

  typedef struct {
    logic        v;
    logic [4:0]  d;
    logic [31:0] x;
  } ent_t;

  // reference model state
  ent_t        m_q[$];
  logic        m_force;
  int          m_age;
  logic [36:0] exp_q[$];

  function automatic vec_t mk(input logic we, input logic jal, input logic [4:0] dst,
                              input logic [31:0] res, input logic [31:0] link,
                              input logic mv, input logic [4:0] mdst, input logic [31:0] mres,
                              input logic e_we, input logic e_wchk, input logic [4:0] e_wn,
                              input logic [31:0] e_wd, input logic e_stall, input logic e_ready,
                              input logic [31:0] e_pend);
    vec_t v;
    v.we = we; v.jal = jal; v.dst = dst; v.res = res; v.link = link;
    v.mv = mv; v.mdst = mdst; v.mres = mres;
    v.e_we = e_we; v.e_wchk = e_wchk; v.e_wn = e_wn; v.e_wd = e_wd;
    v.e_stall = e_stall; v.e_ready = e_ready; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic we, input logic jal, input logic [4:0] dst,
                       input logic [31:0] res, input logic [31:0] link,
                       input logic mv, input logic [4:0] mdst, input logic [31:0] mres);
    core_we = we; core_jal = jal; core_dst = dst; core_res = res; core_link = link;
    mu_valid = mv; mu_dst = mdst; mu_res = mres;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    drive(v.we, v.jal, v.dst, v.res, v.link, v.mv, v.mdst, v.mres);
    #4;
    chk({tag, ".rf_we"}, 64'(rf_we), 64'(v.e_we));
    if (v.e_wchk) begin
      chk({tag, ".rf_wn"}, 64'(rf_wn), 64'(v.e_wn));
      chk({tag, ".rf_wd"}, 64'(rf_wd), 64'(v.e_wd));
    end
    chk({tag, ".stall"}, 64'(core_stall), 64'(v.e_stall));
    chk({tag, ".mu_ready"}, 64'(mu_ready), 64'(v.e_ready));
    chk({tag, ".pend"}, 64'(pend_mask), 64'(v.e_pend));
    tick();
  endtask

  vec_t tbl [14];
  vec_t stv [10];
  vec_t rsv [6];

  initial begin
    // JAL, r0 discard, back-to-back unit results, WAW kill, same-cycle kill, r0 unit result
    tbl[0]  = mk(1'b1, 1'b1, 5'd3, 32'h1234, 32'h0040_0008, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 5'd31, 32'h0040_0008, 1'b0, 1'b1, 32'h0);
    tbl[1]  = mk(1'b1, 1'b0, 5'd0, 32'h55, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0);
    tbl[2]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd5, 32'hAAAA,
                 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0);
    tbl[3]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd6, 32'hBBBB,
                 1'b1, 1'b1, 5'd5, 32'hAAAA, 1'b0, 1'b1, 32'h20);
    tbl[4]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 5'd6, 32'hBBBB, 1'b0, 1'b1, 32'h40);
    tbl[5]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0);
    tbl[6]  = mk(1'b1, 1'b0, 5'd1, 32'h10, 32'h0, 1'b1, 5'd7, 32'h1111,
                 1'b1, 1'b1, 5'd1, 32'h10, 1'b0, 1'b1, 32'h0);
    tbl[7]  = mk(1'b1, 1'b0, 5'd7, 32'h2222, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 5'd7, 32'h2222, 1'b0, 1'b1, 32'h80);
    tbl[8]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b1, 5'd7, 32'h1111, 1'b0, 1'b1, 32'h0);
    tbl[9]  = mk(1'b1, 1'b0, 5'd9, 32'h99, 32'h0, 1'b1, 5'd9, 32'h9999,
                 1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 32'h0);
    tbl[10] = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b1, 5'd9, 32'h9999, 1'b0, 1'b1, 32'h0);
    tbl[11] = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0);
    tbl[12] = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 32'h77,
                 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0);
    tbl[13] = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b1, 5'd0, 32'h77, 1'b0, 1'b1, 32'h0);

    // starvation: fill while the core writes every cycle, forced drain after 4 grants
    stv[0] = mk(1'b1, 1'b0, 5'd1, 32'h101, 32'h0, 1'b1, 5'd10, 32'hA0,
                1'b1, 1'b1, 5'd1, 32'h101, 1'b0, 1'b1, 32'h0);
    stv[1] = mk(1'b1, 1'b0, 5'd2, 32'h102, 32'h0, 1'b1, 5'd11, 32'hA1,
                1'b1, 1'b1, 5'd2, 32'h102, 1'b0, 1'b1, 32'h400);
    stv[2] = mk(1'b1, 1'b0, 5'd3, 32'h103, 32'h0, 1'b1, 5'd12, 32'hA2,
                1'b1, 1'b1, 5'd3, 32'h103, 1'b0, 1'b0, 32'hC00);
    stv[3] = mk(1'b1, 1'b0, 5'd4, 32'h104, 32'h0, 1'b1, 5'd12, 32'hA2,
                1'b1, 1'b1, 5'd4, 32'h104, 1'b0, 1'b0, 32'hC00);
    stv[4] = mk(1'b1, 1'b0, 5'd5, 32'h105, 32'h0, 1'b1, 5'd12, 32'hA2,
                1'b1, 1'b1, 5'd5, 32'h105, 1'b0, 1'b0, 32'hC00);
    stv[5] = mk(1'b1, 1'b0, 5'd6, 32'h106, 32'h0, 1'b1, 5'd12, 32'hA2,
                1'b1, 1'b1, 5'd10, 32'hA0, 1'b1, 1'b0, 32'hC00);
    stv[6] = mk(1'b1, 1'b0, 5'd6, 32'h106, 32'h0, 1'b1, 5'd12, 32'hA2,
                1'b1, 1'b1, 5'd6, 32'h106, 1'b0, 1'b1, 32'h800);
    stv[7] = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b1, 5'd11, 32'hA1, 1'b0, 1'b0, 32'h1800);
    stv[8] = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b1, 5'd12, 32'hA2, 1'b0, 1'b1, 32'h1000);
    stv[9] = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0);

    // reset with two valid buffered entries
    rsv[0] = mk(1'b1, 1'b0, 5'd1, 32'h201, 32'h0, 1'b1, 5'd20, 32'hB0,
                1'b1, 1'b1, 5'd1, 32'h201, 1'b0, 1'b1, 32'h0);
    rsv[1] = mk(1'b1, 1'b0, 5'd2, 32'h202, 32'h0, 1'b1, 5'd21, 32'hB1,
                1'b1, 1'b1, 5'd2, 32'h202, 1'b0, 1'b1, 32'h0010_0000);
    rsv[2] = mk(1'b1, 1'b0, 5'd3, 32'h203, 32'h0, 1'b1, 5'd22, 32'hB2,
                1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0030_0000);
    rsv[3] = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    rsv[4] = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0);
    rsv[5] = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0);

    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rf_we", 64'(rf_we), 64'd0);
    chk("reset.mu_ready", 64'(mu_ready), 64'd0);
    chk("reset.stall", 64'(core_stall), 64'd0);
    chk("reset.pend", 64'(pend_mask), 64'd0);
    chk("reset.state", 64'(dbg_state), 64'd0);
    chk("reset.age", 64'(dbg_age), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);
    chk("final_r7", 64'(rf_shadow[7]), 64'h2222);
    chk("final_r9", 64'(rf_shadow[9]), 64'h99);

    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        chk("starve.state_force", 64'(dbg_state), 64'd1);
        chk("starve.age_cleared", 64'(dbg_age), 64'd0);
      end
      if (i == 6) begin
        chk("starve.state_norm", 64'(dbg_state), 64'd0);
        chk("starve.age_after", 64'(dbg_age), 64'd0);
      end
      if (i == 4) chk("starve.age3", 64'(dbg_age), 64'd3);
      run_vec($sformatf("starve%0d", i), stv[i]);
    end

    for (int i = 0; i < 6; i++) begin
      rst = (i == 2 || i == 3);
      run_vec($sformatf("rstseq%0d", i), rsv[i]);
    end
    rst = 1'b0;

    // random traffic against the reference model
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    rst = 1'b0;
    m_q.delete();
    m_force = 1'b0;
    m_age = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin : rnd
      logic        r_rst, ce, e_we, e_chk, e_stall, e_ready, deq, was_force, acc;
      logic [4:0]  cdst, e_wn;
      logic [31:0] cdata, e_wd, e_pend;
      logic [36:0] exp_w;
      int          n0;
      r_rst = ($urandom_range(0, 99) == 0);
      rst = r_rst;
      drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 4) == 0),
            5'($urandom_range(0, 7)), $urandom, $urandom,
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7)), $urandom);
      ce = 1'b0;
      cdst = core_jal ? 5'd31 : core_dst;
      cdata = core_jal ? core_link : core_res;
      e_we = 1'b0; e_chk = 1'b1; e_wn = 5'd0; e_wd = 32'd0;
      e_stall = 1'b0; e_ready = 1'b0;
      if (!r_rst) begin
        e_stall = m_force;
        e_ready = (m_q.size() < DEPTH);
        ce = core_we && !m_force;
        if (ce) begin
          e_we = (cdst != 5'd0); e_chk = (cdst != 5'd0); e_wn = cdst; e_wd = cdata;
        end else if (m_q.size() > 0) begin
          e_we = m_q[0].v; e_wn = m_q[0].d; e_wd = m_q[0].x;
        end
      end
      e_pend = 32'd0;
      foreach (m_q[i]) if (m_q[i].v) e_pend[m_q[i].d] = 1'b1;
      if (e_we) exp_q.push_back({e_wn, e_wd});
      #4;
      chk($sformatf("rnd%0d.rf_we", cyc), 64'(rf_we), 64'(e_we));
      chk($sformatf("rnd%0d.stall", cyc), 64'(core_stall), 64'(e_stall));
      chk($sformatf("rnd%0d.mu_ready", cyc), 64'(mu_ready), 64'(e_ready));
      chk($sformatf("rnd%0d.pend", cyc), 64'(pend_mask), 64'(e_pend));
      chk($sformatf("rnd%0d.state", cyc), 64'(dbg_state), 64'(m_force));
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        if (rf_we) chk($sformatf("rnd%0d.write", cyc), 64'({rf_wn, rf_wd}), 64'(exp_w));
      end else if (e_chk) begin
        chk($sformatf("rnd%0d.wport", cyc), 64'({rf_wn, rf_wd}), 64'({e_wn, e_wd}));
      end
      if (r_rst) begin
        m_q.delete();
        m_force = 1'b0;
        m_age = 0;
      end else begin
        n0 = m_q.size();
        was_force = m_force;
        deq = !ce && (n0 > 0);
        acc = mu_valid && e_ready;
        if (ce) foreach (m_q[i]) if (m_q[i].d == cdst) m_q[i].v = 1'b0;
        if (deq) void'(m_q.pop_front());
        if (acc) m_q.push_back('{v: (mu_dst != 5'd0) && !(ce && mu_dst == cdst),
                                 d: mu_dst, x: mu_res});
        if (was_force) begin
          m_force = 1'b0;
          m_age = 0;
        end else if (n0 == 0 || deq) begin
          m_age = 0;
        end else if (ce) begin
          m_age++;
          if (m_age == STARVE_MAX) begin
            m_force = 1'b1;
            m_age = 0;
          end
        end
      end
      tick();
    end
    rst = 1'b0;
    chk("rnd.exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Sequences the single register-file write port between the core's writeback (ALU/load result or JAL link) and a long-latency unit (multiply/divide) that returns results out of band. The core has priority. Unit results wait in a small in-order buffer, with write-after-write kill and a starvation guard. The block also resolves the JAL link destination (r31, link data) and sits directly in front of the register-file write port.

## Interface
- DEPTH, 2: pending-buffer entries; power of two, minimum 2.
- STARVE_MAX, 4: consecutive cycles a non-empty buffer may be denied before a forced drain; range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- core_we  in  1  core commits a register write this cycle.
- core_jal  in  1  commit is a JAL: destination forced to r31, data = core_link.
- core_dst  in  5  core destination register (ignored when core_jal=1).
- core_res  in  32  core result data.
- core_link  in  32  JAL link value (PC+4).
- core_stall  out  1  core must hold its current instruction; core_we is ignored while this is high.
- mu_valid  in  1  unit result offered.
- mu_ready  out  1  buffer accepts the result (not full and not in reset).
- mu_dst  in  5  unit destination register.
- mu_res  in  32  unit result data.
- pend_mask  out  32  bit r high when a valid buffered entry targets r; the core stalls reads of r on it.
- rf_we  out  1  register-file write enable.
- rf_wn  out  5  register-file write index.
- rf_wd  out  32  register-file write data.

## Operation
- Effective core write: ce = core_we & ~core_stall. cdst = core_jal ? 5'd31 : core_dst. cdata = core_jal ? core_link : core_res.
- Writes to r0 are discarded: rf_we=0 and no buffer entry. For a unit result this means accepted but stored invalid.
- Buffer: circular FIFO of {valid, dst, data} with read and write pointers plus a count. Enqueue on mu_valid & mu_ready. mu_ready = ~full & ~rst.
- State machine has two states:
  - NORM: port grant goes to the core if ce. Otherwise, if the buffer is non-empty, the head is dequeued, and it is written when its valid bit is set.
  - FORCE: lasts exactly one cycle. core_stall=1, the head is dequeued and written when valid, then the machine returns to NORM.
- Starvation counter age:
  - Increments each NORM cycle in which the buffer is non-empty and ce=1.
  - Clears on any dequeue or when the buffer is empty.
  - When age reaches STARVE_MAX, the next state is FORCE and age clears.
- WAW kill, so the younger core write wins:
  - When ce=1, every stored entry with dst==cdst has its valid bit cleared in the same cycle.
  - An entry enqueued in that same cycle with mu_dst==cdst is stored invalid.
- Invalid entries still occupy a dequeue slot, with rf_we=0 in that slot.
- pend_mask is the OR over stored valid entries, registered with buffer state. It reflects kills and enqueues from the next cycle onward.
- Write-port outputs are combinational from the current state and inputs:
  - Core grant: rf_we=1, rf_wn=cdst, rf_wd=cdata.
  - Buffer grant: rf_we=head.valid, rf_wn=head.dst, rf_wd=head.data.
  - No grant: rf_we=0, rf_wn=0, rf_wd=0.
- Reset values: state NORM, buffer empty, pointers, count and age 0, all valid bits 0, pend_mask=0, core_stall=0, mu_ready=0 while rst=1, rf_we=0.
- Reset asserted mid-operation discards all buffered entries without writing them.

## Timing
- Core write: zero latency, appears on rf_* in the same cycle as core_we.
- Unit result: enqueued at edge N, eligible for the port at cycle N+1 at the earliest. There is no bypass from mu_* to rf_*.
- Full buffer with a simultaneous dequeue: mu_ready stays 0 that cycle, because it is based on count only.
- Enqueue and dequeue in the same cycle leave the count unchanged, and pointers wrap modulo DEPTH.
- Forced-drain timing: with the buffer non-empty and ce=1 every cycle, the block grants the core for STARVE_MAX cycles. The next cycle is FORCE, with core_stall=1 and the buffer head written.
- A kill and a FORCE dequeue cannot coincide, because ce=0 in FORCE.

## Test plan
- Reset, then core_we=1, core_jal=1, core_link=0x0040_0008 -> rf_we=1, rf_wn=31, rf_wd=0x0040_0008 in the same cycle; core_jal=0, core_dst=0 -> rf_we=0.
- Idle core; unit results r5=0xAAAA then r6=0xBBBB on consecutive cycles -> r5 written the cycle after its enqueue, r6 the cycle after that; pend_mask bits 5 and 6 set then cleared in order.
- DEPTH=2: fill buffer while core writes every cycle -> mu_ready=0 at count 2; after 4 core-granted cycles core_stall=1 for one cycle and the head is written; age returns to 0.
- Unit r7=0x1111 buffered, then core writes r7=0x2222 -> entry killed, pend_mask[7]=0 next cycle, and the later dequeue slot has rf_we=0; final r7 value is 0x2222.
- Same-cycle mu_dst=9 enqueue and core write to r9 -> entry stored invalid, r9 written once with the core data.
- Assert rst with 2 valid entries -> no buffered writes occur; pend_mask=0, mu_ready=0 during reset and 1 the cycle after release.
